dff_serial_tx: RTL and testbench
================================

# dff_serial_tx

Parallel-in/serial-out transmitter for the 4-bit register datapath. It accepts a parallel word through a load/ready handshake and shifts it out MSB first on a single serial line, with a frame strobe and a completion pulse. One word of pending buffering allows back-to-back words with a fixed one-cycle inter-word gap. It is the read-out end of the register path, driving serial links and the debug/scan output.

## Interface
- `WIDTH`, default 4: word width in bits (≥2).
- `CLK_DIV`, default 1: clock cycles each serial bit is held (≥1).
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `d` input WIDTH: parallel word to transmit.
- `load` input 1: word-valid strobe; the word is accepted on a rising edge where `load && ready`.
- `ready` output 1: the block can accept a word this cycle.
- `sdo` output 1: serial data, MSB first.
- `sframe` output 1: high while `sdo` carries a valid bit.
- `busy` output 1: high in SHIFT or DONE.
- `done` output 1: one-cycle pulse after the last bit of each word.

## Operation
- Reset (`reset_n`=0, asynchronous): state IDLE, shift register, pending buffer, and bit/divider counters cleared. Outputs: `sdo`=0, `sframe`=0, `busy`=0, `done`=0, `ready`=1.
- Storage: shift register `sr[WIDTH-1:0]`, pending buffer `pend` with flag `pend_v`, bit counter, and divider counter (0..CLK_DIV-1).
- `ready` = !`pend_v` (registered-state derived, no combinational path from `load`).
- `load` while `ready`=0: ignored, no state change. `d` is sampled only on accept.
- States:
  - IDLE: `sdo`=0, `sframe`=0, `busy`=0. On accept: `sr`<=`d`, counters cleared, go to SHIFT.
  - SHIFT: `sdo`=`sr[WIDTH-1]`, `sframe`=1, `busy`=1. The divider counts 0..CLK_DIV-1. At wrap, `sr` shifts left (zero fill) and the bit counter increments. At wrap with bit count = WIDTH-1, go to DONE. An accept in SHIFT writes `pend`<=`d` and sets `pend_v`.
  - DONE (exactly 1 cycle): `sdo`=0, `sframe`=0, `busy`=1, `done`=1. Next state:
    - If `pend_v`: `sr`<=`pend`, clear `pend_v`, go to SHIFT.
    - Else if accept this cycle: `sr`<=`d`, go to SHIFT. The word is not written to `pend`.
    - Else: go to IDLE.
- Reset during SHIFT/DONE aborts the word and discards `pend`. No `done` is generated.
- `d` changing after accept has no effect on the transmitted word.

## Timing
- Accept at edge N: first bit (MSB) on `sdo` from edge N through N+CLK_DIV, with `sframe` rising at edge N.
- Bit k (k=0 is MSB) is valid for cycles [N + k·CLK_DIV, N + (k+1)·CLK_DIV).
- `done` is high for the one cycle starting at edge N + WIDTH·CLK_DIV.
- Word period is WIDTH·CLK_DIV + 1 cycles. Back-to-back words have exactly one idle bit cycle (the DONE cycle) between frames.
- `ready` falls on the edge after a SHIFT-state accept. It rises on the edge leaving DONE when `pend` is consumed.
- All outputs are registered or decoded from registered state only.

## Test plan
- Reset values: hold `reset_n`=0 → `sdo`=0, `sframe`=0, `busy`=0, `done`=0, `ready`=1. Release and idle 10 cycles → outputs unchanged.
- Single word, WIDTH=4, CLK_DIV=1: load `d`=4'b1011 in IDLE → `sdo` = 1,0,1,1 on four consecutive cycles with `sframe`=1, then `done`=1 for 1 cycle, then IDLE.
- CLK_DIV=3: load 4'b0110 → each bit held 3 cycles (0,0,0,1,1,1,1,1,1,0,0,0), and `done` pulses at cycle 12 after accept.
- Back-to-back: load 4'hA, then 4'h5 during SHIFT → `ready`=0 until DONE. Output is 1010, a gap of 1 cycle (`done`=1), then 0101. A third load while `ready`=0 is ignored.
- DONE-cycle load with `pend` empty: load 4'hC exactly in the DONE cycle → SHIFT next edge, transmits 1100, and `pend_v` stays 0.
- Reset mid-word: assert `reset_n`=0 after the second bit of 4'hF with a pending 4'h3 → outputs reset immediately. No `done`, `pend` discarded, and the next load transmits normally.

Source files
------------

// File: rtl/dff_serial_tx.sv
// dff_serial_tx: parallel-in / serial-out transmitter, MSB first.
// A word is taken on a rising clk edge where load && ready. Each bit is held
// for CLK_DIV cycles on sdo, with sframe high. A one-cycle DONE state follows
// each word and raises done. One pending word may be queued during SHIFT so
// that back-to-back frames are separated only by that DONE cycle.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   d        parallel word, sampled only on accept
//   load     word-valid strobe
//   ready    can accept a word this cycle (= !pend_v)
//   sdo      serial data out, MSB first
//   sframe   high while sdo carries a valid bit
//   busy     high in SHIFT or DONE
//   done     one-cycle pulse after the last bit of a word
module dff_serial_tx #(
    parameter int WIDTH   = 4,
    parameter int CLK_DIV = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    output logic             ready,
    output logic             sdo,
    output logic             sframe,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // CLK_DIV=1 would give a zero-width counter; keep at least one bit.
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [WIDTH-1:0] pend, pend_nxt;
    logic             pend_v, pend_v_nxt;
    logic [BW-1:0]    bitcnt, bitcnt_nxt;
    logic [DW-1:0]    divcnt, divcnt_nxt;
    logic             accept;

    // ready depends only on registered state, so accept never loops back
    // into ready combinationally.
    assign ready  = !pend_v;
    assign accept = load && ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            sr     <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
            bitcnt <= '0;
            divcnt <= '0;
        end else begin
            state  <= state_nxt;
            sr     <= sr_nxt;
            pend   <= pend_nxt;
            pend_v <= pend_v_nxt;
            bitcnt <= bitcnt_nxt;
            divcnt <= divcnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sr_nxt     = sr;
        pend_nxt   = pend;
        pend_v_nxt = pend_v;
        bitcnt_nxt = bitcnt;
        divcnt_nxt = divcnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    sr_nxt     = d;
                    bitcnt_nxt = '0;
                    divcnt_nxt = '0;
                    state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                if (accept) begin
                    pend_nxt   = d;
                    pend_v_nxt = 1'b1;
                end
                if (divcnt == DIV_LAST) begin
                    divcnt_nxt = '0;
                    sr_nxt     = {sr[WIDTH-2:0], 1'b0};
                    bitcnt_nxt = bitcnt + 1'b1;
                    if (bitcnt == BIT_LAST) state_nxt = DONE;
                end else begin
                    divcnt_nxt = divcnt + 1'b1;
                end
            end
            DONE: begin
                bitcnt_nxt = '0;
                divcnt_nxt = '0;
                // A queued word has priority; ready is low here in that
                // case, so no new accept can collide with it.
                if (pend_v) begin
                    sr_nxt     = pend;
                    pend_v_nxt = 1'b0;
                    state_nxt  = SHIFT;
                end else if (accept) begin
                    sr_nxt    = d;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sframe = (state == SHIFT);
    assign sdo    = (state == SHIFT) && sr[WIDTH-1];
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

endmodule

// File: tb/tb_dff_serial_tx.sv
// Directed bench for dff_serial_tx. Two instances share clk/reset_n:
// dut (CLK_DIV=1) and dut3 (CLK_DIV=3). Outputs are compared as the vector
// {sdo, sframe, busy, done, ready}; inputs change and outputs are sampled
// 1 time unit after the rising edge.
module tb_dff_serial_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] d, d3;
    logic       load, load3;
    logic       ready, sdo, sframe, busy, done;
    logic       ready3, sdo3, sframe3, busy3, done3;

    int ncmp = 0;
    int nerr = 0;

    dff_serial_tx #(.WIDTH(4), .CLK_DIV(1)) dut (
        .clk(clk), .reset_n(reset_n), .d(d), .load(load), .ready(ready),
        .sdo(sdo), .sframe(sframe), .busy(busy), .done(done)
    );

    dff_serial_tx #(.WIDTH(4), .CLK_DIV(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .d(d3), .load(load3), .ready(ready3),
        .sdo(sdo3), .sframe(sframe3), .busy(busy3), .done(done3)
    );

    always #5 clk = ~clk;

    wire [4:0] obs  = {sdo, sframe, busy, done, ready};
    wire [4:0] obs3 = {sdo3, sframe3, busy3, done3, ready3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load = 1'b0; load3 = 1'b0; d = 4'h0; d3 = 4'h0;
        #3;
        ncmp++;
        if (obs !== 5'b00001) begin
            nerr++; $display("FAIL reset_hold: got %b want %b", obs, 5'b00001);
        end
        ncmp++;
        if (obs3 !== 5'b00001) begin
            nerr++; $display("FAIL reset_hold_div3: got %b want %b", obs3, 5'b00001);
        end
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            ncmp++;
            if (obs !== 5'b00001) begin
                nerr++; $display("FAIL reset_idle[%0d]: got %b want %b", i, obs, 5'b00001);
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] w = 4'b1011;
        d = w; load = 1'b1;
        tick();
        load = 1'b0; d = 4'h0;
        for (int k = 0; k < 4; k++) begin
            ncmp++;
            if (obs !== {w[3-k], 4'b1101}) begin
                nerr++; $display("FAIL single_bit[%0d]: got %b want %b", k, obs, {w[3-k], 4'b1101});
            end
            tick();
        end
        ncmp++;
        if (obs !== 5'b00111) begin
            nerr++; $display("FAIL single_done: got %b want %b", obs, 5'b00111);
        end
        tick();
        ncmp++;
        if (obs !== 5'b00001) begin
            nerr++; $display("FAIL single_idle: got %b want %b", obs, 5'b00001);
        end
    endtask

    task automatic test_clkdiv();
        logic [11:0] bits = 12'b000111111000;
        d3 = 4'b0110; load3 = 1'b1;
        tick();
        load3 = 1'b0; d3 = 4'hF;
        for (int i = 0; i < 12; i++) begin
            ncmp++;
            if (obs3 !== {bits[11-i], 4'b1101}) begin
                nerr++; $display("FAIL div3_bit[%0d]: got %b want %b", i, obs3, {bits[11-i], 4'b1101});
            end
            tick();
        end
        ncmp++;
        if (obs3 !== 5'b00111) begin
            nerr++; $display("FAIL div3_done_c12: got %b want %b", obs3, 5'b00111);
        end
        tick();
        ncmp++;
        if (obs3 !== 5'b00001) begin
            nerr++; $display("FAIL div3_idle: got %b want %b", obs3, 5'b00001);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] wa = 4'hA;
        logic [3:0] wb = 4'h5;
        logic       rdy;
        d = wa; load = 1'b1;
        tick();
        // word A: queue B on bit 0, try an ignored load of F on bit 1
        for (int k = 0; k < 4; k++) begin
            rdy = (k == 0);
            ncmp++;
            if (obs !== {wa[3-k], 3'b110, rdy}) begin
                nerr++; $display("FAIL b2b_a_bit[%0d]: got %b want %b", k, obs, {wa[3-k], 3'b110, rdy});
            end
            if (k == 0) begin d = wb; load = 1'b1; end
            else if (k == 1) begin d = 4'hF; load = 1'b1; end
            else begin load = 1'b0; d = 4'h0; end
            tick();
        end
        ncmp++;
        if (obs !== 5'b00110) begin
            nerr++; $display("FAIL b2b_gap: got %b want %b", obs, 5'b00110);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            ncmp++;
            if (obs !== {wb[3-k], 4'b1101}) begin
                nerr++; $display("FAIL b2b_b_bit[%0d]: got %b want %b", k, obs, {wb[3-k], 4'b1101});
            end
            tick();
        end
        ncmp++;
        if (obs !== 5'b00111) begin
            nerr++; $display("FAIL b2b_done_b: got %b want %b", obs, 5'b00111);
        end
        tick();
        ncmp++;
        if (obs !== 5'b00001) begin
            nerr++; $display("FAIL b2b_idle: got %b want %b", obs, 5'b00001);
        end
    endtask

    task automatic test_done_load();
        logic [3:0] wc = 4'hC;
        d = 4'h9; load = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick(); tick(); tick();
        ncmp++;
        if (obs !== 5'b00111) begin
            nerr++; $display("FAIL dload_done: got %b want %b", obs, 5'b00111);
        end
        d = wc; load = 1'b1;
        tick();
        load = 1'b0; d = 4'h3;
        // ready stays high throughout: the word went straight into sr
        for (int k = 0; k < 4; k++) begin
            ncmp++;
            if (obs !== {wc[3-k], 4'b1101}) begin
                nerr++; $display("FAIL dload_bit[%0d]: got %b want %b", k, obs, {wc[3-k], 4'b1101});
            end
            tick();
        end
        ncmp++;
        if (obs !== 5'b00111) begin
            nerr++; $display("FAIL dload_done2: got %b want %b", obs, 5'b00111);
        end
        tick();
        ncmp++;
        if (obs !== 5'b00001) begin
            nerr++; $display("FAIL dload_idle: got %b want %b", obs, 5'b00001);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] w6 = 4'h6;
        d = 4'hF; load = 1'b1;
        tick();
        d = 4'h3;            // queued into pend on the next edge
        tick();
        load = 1'b0;
        ncmp++;
        if (obs !== 5'b11100) begin
            nerr++; $display("FAIL rmid_pending: got %b want %b", obs, 5'b11100);
        end
        tick();
        reset_n = 1'b0;
        #1;
        ncmp++;
        if (obs !== 5'b00001) begin
            nerr++; $display("FAIL rmid_async: got %b want %b", obs, 5'b00001);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            ncmp++;
            if (obs !== 5'b00001) begin
                nerr++; $display("FAIL rmid_quiet[%0d]: got %b want %b", i, obs, 5'b00001);
            end
        end
        d = w6; load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ncmp++;
            if (obs !== {w6[3-k], 4'b1101}) begin
                nerr++; $display("FAIL rmid_next_bit[%0d]: got %b want %b", k, obs, {w6[3-k], 4'b1101});
            end
            tick();
        end
        ncmp++;
        if (obs !== 5'b00111) begin
            nerr++; $display("FAIL rmid_next_done: got %b want %b", obs, 5'b00111);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_clkdiv();
        test_back_to_back();
        test_done_load();
        test_reset_mid();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
